// File: rtl/out_mon_pkg.sv
// Shared types and default parameters for the out-stage monitor.
package out_mon_pkg;

  // Default sample width, matching the upstream out stream.
  localparam int DW_DEFAULT = 11;

  // Default log2 of the averaging window depth (window of 4 samples).
  localparam int WIN_LOG2_DEFAULT = 2;

  // Window fill state: empty, partially filled, full and sliding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } mon_state_t;

endpackage : out_mon_pkg

// File: rtl/out_mon_window.sv
// Sample window for the out-stage monitor: an N-entry shift register
// with a running sum.
// The oldest entry is only subtracted once the window is full, so the
// sum stays exact while the window is still filling.
module out_mon_window
  import out_mon_pkg::*;
#(
  parameter int DW       = DW_DEFAULT,
  parameter int WIN_LOG2 = WIN_LOG2_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          shift,
  input  logic          run,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] avg_next
);

  localparam int N  = 1 << WIN_LOG2;
  localparam int SW = DW + WIN_LOG2;

  logic [DW-1:0] win [N];
  logic [SW-1:0] sum;
  logic [SW-1:0] sum_next;
  logic [DW-1:0] oldest;

  // Tap the entry that leaves the window on this accept.
  // Subtract first so the intermediate value never exceeds the final sum.
  always_comb begin
    oldest   = run ? win[N-1] : '0;
    sum_next = sum - SW'(oldest) + SW'(in_data);
    avg_next = sum_next[SW-1:WIN_LOG2];
  end

  // Shift the new sample in on each accept; clear empties the window.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < N; i++) begin
        win[i] <= '0;
      end
      sum <= '0;
    end else if (shift) begin
      for (int i = N - 1; i > 0; i--) begin
        win[i] <= win[i-1];
      end
      win[0] <= in_data;
      sum    <= sum_next;
    end
  end

endmodule : out_mon_window

// File: rtl/out_stage_monitor.sv
// Out-stage monitor: windowed average, peak tracking and a threshold
// alarm on the out result stream.
// clr beats in_valid, and rst beats both.
module out_stage_monitor
  import out_mon_pkg::*;
#(
  parameter int DW        = DW_DEFAULT,
  parameter int WIN_LOG2  = WIN_LOG2_DEFAULT,
  parameter int ALARM_CNT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DW-1:0]       in_data,
  input  logic                clr,
  input  logic [DW-1:0]       thresh,
  output logic                avg_valid,
  output logic [DW-1:0]       avg_out,
  output logic [DW-1:0]       peak_out,
  output logic                alarm,
  output logic [WIN_LOG2:0]   fill_cnt
);

  localparam int N  = 1 << WIN_LOG2;
  localparam int FW = WIN_LOG2 + 1;
  localparam int HW = $clog2(ALARM_CNT + 1);

  mon_state_t    state_q;
  mon_state_t    state_d;
  logic [FW-1:0] fill_d;
  logic          accept;
  logic          new_avg;
  logic [DW-1:0] avg_next;
  logic [DW-1:0] peak_d;
  logic [HW-1:0] hi_cnt;
  logic [HW-1:0] hi_d;

  assign accept = in_valid && !clr;

  out_mon_window #(
    .DW       (DW),
    .WIN_LOG2 (WIN_LOG2)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .shift    (accept),
    .run      (state_q == RUN),
    .in_data  (in_data),
    .avg_next (avg_next)
  );

  // Next state and fill count; without an accept everything holds.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_cnt;
    if (clr) begin
      state_d = IDLE;
      fill_d  = '0;
    end else if (in_valid) begin
      case (state_q)
        IDLE: begin
          fill_d  = FW'(1);
          state_d = (N == 1) ? RUN : FILL;
        end
        FILL: begin
          fill_d  = fill_cnt + FW'(1);
          state_d = (fill_cnt + FW'(1) == FW'(N)) ? RUN : FILL;
        end
        RUN: begin
          fill_d  = fill_cnt;
          state_d = RUN;
        end
        default: begin
          fill_d  = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and fill count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      fill_cnt <= '0;
    end else begin
      state_q  <= state_d;
      fill_cnt <= fill_d;
    end
  end

  // A new average exists whenever an accept leaves the window full.
  // The over-threshold run length saturates at ALARM_CNT.
  always_comb begin
    new_avg = accept && (fill_d == FW'(N));
    peak_d  = (in_data > peak_out) ? in_data : peak_out;
    hi_d    = '0;
    if (avg_next > thresh) begin
      hi_d = (hi_cnt == HW'(ALARM_CNT)) ? hi_cnt : hi_cnt + HW'(1);
    end
  end

  // Output registers: average, alarm and peak, all zeroed by rst or clr.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      avg_valid <= 1'b0;
      avg_out   <= '0;
      peak_out  <= '0;
      hi_cnt    <= '0;
      alarm     <= 1'b0;
    end else begin
      avg_valid <= new_avg;
      if (new_avg) begin
        avg_out <= avg_next;
        hi_cnt  <= hi_d;
        alarm   <= (hi_d == HW'(ALARM_CNT));
      end
      if (accept) begin
        peak_out <= peak_d;
      end
    end
  end

endmodule : out_stage_monitor

// File: tb/tb_out_stage_monitor.sv
// Scoreboard bench for out_stage_monitor: stimulus pushes hand-computed
// expected averages, and a monitor pops them on every avg_valid pulse.
module tb_out_stage_monitor;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [10:0] in_data;
  logic        clr;
  logic [10:0] thresh;
  logic        avg_valid;
  logic [10:0] avg_out;
  logic [10:0] peak_out;
  logic        alarm;
  logic [2:0]  fill_cnt;

  typedef struct {
    logic [10:0] avg;
    logic        alarm;
    logic [10:0] peak;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  out_stage_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clr       (clr),
    .thresh    (thresh),
    .avg_valid (avg_valid),
    .avg_out   (avg_out),
    .peak_out  (peak_out),
    .alarm     (alarm),
    .fill_cnt  (fill_cnt)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one value and log a FAIL line on a difference.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs; optionally push the average it should produce.
  task automatic applyStimulus(input logic v, input logic [10:0] d, input logic c,
                               input logic push, input logic [10:0] ea,
                               input logic el, input logic [10:0] ep);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    clr      = c;
    if (push) begin
      e.avg   = ea;
      e.alarm = el;
      e.peak  = ep;
      sbq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 1'b0, 11'd0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_avg_valid"}, int'(avg_valid), 0);
    checkOutput({tag, "_avg_out"},   int'(avg_out),   0);
    checkOutput({tag, "_peak_out"},  int'(peak_out),  0);
    checkOutput({tag, "_alarm"},     int'(alarm),     0);
    checkOutput({tag, "_fill_cnt"},  int'(fill_cnt),  0);
  endtask

  // Monitor: every avg_valid pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && avg_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_avg_valid: got avg_out=%0d, expected no pulse", avg_out);
      end else begin
        e = sbq.pop_front();
        checkOutput("sb_avg_out",  int'(avg_out),  int'(e.avg));
        checkOutput("sb_alarm",    int'(alarm),    int'(e.alarm));
        checkOutput("sb_peak_out", int'(peak_out), int'(e.peak));
      end
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    clr      = 1'b0;
    thresh   = 11'd2047;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkAllZero("reset");

    $display("[TB] four accepts of 15");
    applyStimulus(1'b1, 11'd15, 1'b0, 1'b0, 11'd0,  1'b0, 11'd0);
    applyStimulus(1'b1, 11'd15, 1'b0, 1'b0, 11'd0,  1'b0, 11'd0);
    applyStimulus(1'b1, 11'd15, 1'b0, 1'b0, 11'd0,  1'b0, 11'd0);
    applyStimulus(1'b1, 11'd15, 1'b0, 1'b1, 11'd15, 1'b0, 11'd15);
    idle(2);
    checkOutput("t1_fill_cnt", int'(fill_cnt), 4);
    checkOutput("t1_peak_out", int'(peak_out), 15);
    checkOutput("t1_avg_hold", int'(avg_out), 15);
    checkOutput("t1_avg_valid_low", int'(avg_valid), 0);

    $display("[TB] clr then ramp 0..7");
    applyStimulus(1'b0, 11'd0, 1'b1, 1'b0, 11'd0, 1'b0, 11'd0);
    idle(1);
    checkAllZero("clr1");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 11'(i), 1'b0, (i >= 3), 11'(i - 2), 1'b0, 11'(i));
    end
    idle(2);
    checkOutput("t2_peak_out", int'(peak_out), 7);
    checkOutput("t2_avg_hold", int'(avg_out), 5);

    $display("[TB] 2047 with gaps");
    applyStimulus(1'b0, 11'd0, 1'b1, 1'b0, 11'd0, 1'b0, 11'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 11'd2047, 1'b0, (i == 3), 11'd2047, 1'b0, 11'd2047);
      idle(2);
    end
    checkOutput("t3_avg_out", int'(avg_out), 2047);
    checkOutput("t3_fill_cnt", int'(fill_cnt), 4);

    $display("[TB] alarm with thresh=100");
    applyStimulus(1'b0, 11'd0, 1'b1, 1'b0, 11'd0, 1'b0, 11'd0);
    thresh = 11'd100;
    applyStimulus(1'b1, 11'd200, 1'b0, 1'b0, 11'd0,   1'b0, 11'd0);
    applyStimulus(1'b1, 11'd200, 1'b0, 1'b0, 11'd0,   1'b0, 11'd0);
    applyStimulus(1'b1, 11'd200, 1'b0, 1'b0, 11'd0,   1'b0, 11'd0);
    applyStimulus(1'b1, 11'd200, 1'b0, 1'b1, 11'd200, 1'b0, 11'd200);
    applyStimulus(1'b1, 11'd200, 1'b0, 1'b1, 11'd200, 1'b0, 11'd200);
    applyStimulus(1'b1, 11'd200, 1'b0, 1'b1, 11'd200, 1'b1, 11'd200);
    applyStimulus(1'b1, 11'd0,   1'b0, 1'b1, 11'd150, 1'b1, 11'd200);
    applyStimulus(1'b1, 11'd0,   1'b0, 1'b1, 11'd100, 1'b0, 11'd200);
    applyStimulus(1'b1, 11'd0,   1'b0, 1'b1, 11'd50,  1'b0, 11'd200);
    idle(1);
    checkOutput("t4_alarm_low", int'(alarm), 0);

    $display("[TB] clr together with in_valid in RUN");
    applyStimulus(1'b1, 11'd500, 1'b1, 1'b0, 11'd0, 1'b0, 11'd0);
    idle(1);
    checkAllZero("clr_drop");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 11'd10, 1'b0, 1'b0, 11'd0, 1'b0, 11'd0);
    end
    idle(1);
    checkOutput("t5_fill_cnt", int'(fill_cnt), 3);
    applyStimulus(1'b1, 11'd10, 1'b0, 1'b1, 11'd10, 1'b0, 11'd10);
    idle(1);

    $display("[TB] rst mid-RUN with in_valid");
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 11'd900;
    clr      = 1'b0;
    @(negedge clk);
    checkAllZero("rst_run");
    rst      = 1'b0;
    in_valid = 1'b0;
    applyStimulus(1'b1, 11'd5, 1'b0, 1'b0, 11'd0, 1'b0, 11'd0);
    idle(1);
    checkOutput("t6_peak_out", int'(peak_out), 5);
    checkOutput("t6_fill_cnt", int'(fill_cnt), 1);

    for (int k = 0; k < 20 && sbq.size() != 0; k++) @(negedge clk);
    checkOutput("sb_drain_pending", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_out_stage_monitor

// File: doc/out_stage_monitor.md
OUT_STAGE_MONITOR -- requirements
Module: out_stage_monitor

Downstream consumer of the 11-bit `out` result stream: windowed average, peak tracking and threshold alarm.

Interface
REQ-001 Parameter DW, default 11, sample data width; it matches the upstream `out` width.
REQ-002 Parameter WIN_LOG2, default 2, log2 of the averaging window depth (window depth N = 4).
REQ-003 Parameter ALARM_CNT, default 3, number of consecutive over-threshold averages that raise the alarm.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  in_data is accepted on a rising edge where in_valid=1.
REQ-007 in_data  input  DW  sample from the upstream stage, unsigned.
REQ-008 clr  input  1  synchronous soft clear of the window, peak and alarm.
REQ-009 thresh  input  DW  unsigned alarm threshold, sampled every cycle.
REQ-010 avg_valid  output  1  one-cycle pulse: avg_out updated.
REQ-011 avg_out  output  DW  window average, unsigned, truncated.
REQ-012 peak_out  output  DW  maximum accepted sample since the last reset or clr.
REQ-013 alarm  output  1  level: ALARM_CNT consecutive averages strictly above thresh.
REQ-014 fill_cnt  output  WIN_LOG2+1  number of samples currently held in the window, 0..N.

Function
REQ-015 The FSM SHALL have three states.
- IDLE: fill_cnt=0.
- FILL: 0<fill_cnt<N.
- RUN: fill_cnt=N.
REQ-016 Transitions SHALL be:
- IDLE->FILL on accept.
- FILL->RUN on the accept that makes fill_cnt=N.
- RUN->RUN on accept.
- Any state->IDLE on clr.
- The state SHALL hold when there is no accept.
REQ-017 The window SHALL be an N-entry shift register. An accept shifts in in_data and, in RUN, discards the oldest entry.
REQ-018 Running sum width SHALL be DW+WIN_LOG2 bits, so it never overflows.
- On accept: sum_next = sum + in_data - oldest.
- oldest = 0 unless the state is RUN.
REQ-019 avg_out SHALL equal sum_next >> WIN_LOG2, registered on the accepting edge when the post-accept fill_cnt=N.
- avg_valid SHALL pulse high for exactly the following cycle (latency 1).
REQ-020 No avg_valid SHALL occur for the first N-1 accepts after reset or clr.
- avg_out SHALL hold its last value when avg_valid=0.
REQ-021 Gaps in in_valid SHALL be tolerated: the window contents and sum hold unchanged.
- One accept SHALL produce at most one avg_valid.
REQ-022 peak_out SHALL update on each accept to max(peak_out, in_data).
REQ-023 hi_cnt, on each new average:
- if avg > thresh: hi_cnt = min(hi_cnt+1, ALARM_CNT);
- else hi_cnt = 0.
- alarm = (hi_cnt == ALARM_CNT), updated on the same edge as avg_out.
REQ-024 avg_out equal to thresh SHALL count as not over threshold.
REQ-025 If clr and in_valid are both high in the same cycle, clr SHALL win and the sample SHALL be dropped.
REQ-026 clr SHALL zero the window, sum, fill_cnt, peak_out, hi_cnt, alarm and avg_valid.
- avg_out SHALL be zeroed as well.

Reset
REQ-027 On rst=1 at a rising edge, the block SHALL enter IDLE and drive all outputs to 0.
- All outputs: avg_valid, avg_out, peak_out, alarm, fill_cnt.
- Internal window, sum and hi_cnt SHALL also be zeroed.
REQ-028 rst SHALL take priority over clr and in_valid, including when asserted mid-RUN.
REQ-029 The first accept SHALL be possible on the first edge with rst=0.

Structure
REQ-030 Shared package out_mon_pkg SHALL hold:
- the FSM state enum (IDLE, FILL, RUN);
- the DW default, 11;
- the WIN_LOG2 default, 2.
REQ-031 Sub-module out_mon_window SHALL hold the shift register, running sum and oldest-entry tap.
- The top level SHALL hold the FSM, peak logic, alarm counter and output registers.

Verification
REQ-032 Reset, then 4 accepts of 15: avg_valid exactly once, one cycle after the 4th accept, avg_out=15, peak_out=15, fill_cnt=4.
REQ-033 Accept ramp 0..7 back-to-back: averages 1, 2, 3, 4, 5 (truncated) on consecutive cycles; peak_out=7.
REQ-034 4 accepts of 2047 interleaved with idle cycles: avg_out=2047, no overflow, exactly one avg_valid, and none during the gaps.
REQ-035 thresh=100; accept 200 x6, then 0 x3:
- alarm rises with the 3rd average (after the 6th accept);
- 0 x2: averages 150 and 100; the third 0 gives average 50.
- alarm stays high through the 150 average and falls at the 100 average (equal to thresh is not over).
REQ-036 In RUN, assert clr together with in_valid=1, data 500: sample dropped, state IDLE, all outputs 0.
- The next 3 accepts produce no avg_valid.
REQ-037 Assert rst mid-RUN with in_valid=1: next cycle all outputs 0; peak_out ignores the dropped sample.
